// File: rtl/arb_buf_pkg.sv
// Shared types, default sizes and helpers for the arbiter input buffer.
package arb_buf_pkg;

  localparam int DEF_N_PORTS = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int MAX_PORTS   = 32;
  localparam int PTR_W       = $clog2(DEF_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  typedef logic [DEF_DATA_W-1:0] flit_t;
  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  // Binary index of the set bit; only meaningful for one-hot input.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_input_buffer_if.sv
// Buffer <-> source/arbiter/downstream bundle; err_flags exists only with ARB_BUF_ERR_EN.
interface arb_input_buffer_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS-1:0]        in_ready;
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS-1:0]        request;
  logic [N_PORTS-1:0]        grant;
  logic                      any_grant;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_port;
`ifdef ARB_BUF_ERR_EN
  logic [1:0]                err_flags;
`endif

  modport slave (
    input  in_valid, in_data, grant, any_grant, out_ready,
`ifdef ARB_BUF_ERR_EN
    output err_flags,
`endif
    output in_ready, request, out_valid, out_data, out_port
  );

  modport master (
    output in_valid, in_data, grant, any_grant, out_ready,
`ifdef ARB_BUF_ERR_EN
    input  err_flags,
`endif
    input  in_ready, request, out_valid, out_data, out_port
  );

endinterface

// File: rtl/flit_fifo.sv
// Single-clock per-port flit FIFO; push ignored when full, pop ignored when empty.
module flit_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              push_en;
  logic              pop_en;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_input_buffer.sv
// Per-port input buffers feeding the arbiter, with a registered output stage.
// Optional sticky grant-error flags are enabled by defining ARB_BUF_ERR_EN.
module arb_input_buffer
  import arb_buf_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input logic clk,
  input logic reset,
  arb_input_buffer_if.slave bus
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] empty;
  logic [N_PORTS-1:0] push;
  logic [N_PORTS-1:0] pop;
  logic [DATA_W-1:0]  head [N_PORTS];
  logic [DATA_W-1:0]  grant_head;
  logic               out_free;
  logic               grant_onehot;
  logic               valid_grant;

  assign out_free     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = ~full;
  // Requests drop while the output stalls so the arbiter pointer holds still.
  assign bus.request  = ~empty & {N_PORTS{out_free}};
  assign push         = bus.in_valid & ~full;
  assign grant_onehot = (bus.grant != '0) &&
                        ((bus.grant & (bus.grant - N_PORTS'(1))) == '0);
  assign valid_grant  = grant_onehot && ((bus.grant & bus.request) == bus.grant);
  assign pop          = valid_grant ? bus.grant : '0;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    flit_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (bus.in_data[g*DATA_W +: DATA_W]),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  always_comb begin
    grant_head = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      grant_head = grant_head | (head[i] & {DATA_W{bus.grant[i]}});
    end
  end

  // Output stage: reload on any valid pop, otherwise drain when accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_port  <= '0;
    end else if (valid_grant) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= grant_head;
      bus.out_port  <= IDX_W'(onehot_to_idx(MAX_PORTS'(bus.grant)));
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef ARB_BUF_ERR_EN
  logic [1:0] err_set;

  assign err_set[0] = (bus.grant != '0) && !grant_onehot;
  assign err_set[1] = ((bus.grant & ~bus.request) != '0) ||
                      (bus.any_grant != (|bus.grant));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.err_flags <= '0;
    else        bus.err_flags <= bus.err_flags | err_set;
  end
`else
  logic unused_any_grant;
  assign unused_any_grant = bus.any_grant;
`endif

endmodule

// File: tb/tb_arb_input_buffer.sv
// Randomized bench for arb_input_buffer against a queue-based reference model.
module tb_arb_input_buffer;
  import arb_buf_pkg::*;

  localparam int NP = DEF_N_PORTS;
  localparam int DW = DEF_DATA_W;
  localparam int DP = DEF_DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arb_input_buffer_if #(.N_PORTS(NP), .DATA_W(DW)) bus ();

  arb_input_buffer #(.N_PORTS(NP), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  flit_t q [NP][$];
  bit    m_ov;
  flit_t m_od;
  int    m_op;
  logic [1:0] m_err;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) q[i].delete();
    m_ov  = 0;
    m_od  = '0;
    m_op  = 0;
    m_err = '0;
  endtask

  function automatic logic [NP-1:0] m_request(input logic ordy);
    logic [NP-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i] = (q[i].size() > 0) && (!m_ov || ordy);
    return r;
  endfunction

  task automatic check_outputs();
    logic [NP-1:0] rdy;
    for (int i = 0; i < NP; i++) rdy[i] = (q[i].size() < DP);
    chk_eq("in_ready",  64'(bus.in_ready),  64'(rdy));
    chk_eq("request",   64'(bus.request),   64'(m_request(bus.out_ready)));
    chk_eq("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk_eq("out_data",  64'(bus.out_data),  64'(m_od));
    chk_eq("out_port",  64'(bus.out_port),  64'(m_op));
`ifdef ARB_BUF_ERR_EN
    chk_eq("err_flags", 64'(bus.err_flags), 64'(m_err));
`endif
  endtask

  // Drive one cycle's inputs after the falling edge, check, then advance the model.
  task automatic step(input logic [NP-1:0] iv, input logic [NP*DW-1:0] id,
                      input logic [NP-1:0] gr, input logic ag, input logic ordy);
    logic [NP-1:0] req, pu;
    int ones, gi;
    bit vg;
    flit_t f;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.grant     = gr;
    bus.any_grant = ag;
    bus.out_ready = ordy;
    #1;
    check_outputs();
    req  = m_request(ordy);
    ones = $countones(gr);
    gi   = 0;
    for (int i = 0; i < NP; i++) if (gr[i]) gi = i;
    vg = (ones == 1) && (q[gi].size() > 0) && (!m_ov || ordy);
    if (ones > 1) m_err[0] = 1'b1;
    if (((gr & ~req) != '0) || (ag != (|gr))) m_err[1] = 1'b1;
    for (int i = 0; i < NP; i++) pu[i] = iv[i] && (q[i].size() < DP);
    if (vg) begin
      f    = q[gi].pop_front();
      m_ov = 1;
      m_od = f;
      m_op = gi;
    end else if (ordy) begin
      m_ov = 0;
    end
    for (int i = 0; i < NP; i++) if (pu[i]) q[i].push_back(id[i*DW +: DW]);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [NP*DW-1:0] d;
    logic [NP-1:0] iv, gr, req;
    logic ordy, ag;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.grant     = '0;
    bus.any_grant = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    #1 check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Single flit on port 2, then its grant, then drain.
    d = '0;
    d[2*DW +: DW] = 32'hA5;
    step(4'b0100, d, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, d, 4'b0100, 1'b1, 1'b1);
    step(4'b0000, d, 4'b0000, 1'b0, 1'b1);

    // Fill port 0 past capacity, then drain it in order.
    for (int k = 0; k < DP + 1; k++) begin
      d = '0;
      d[DW-1:0] = 32'h100 + 32'(k);
      step(4'b0001, d, 4'b0000, 1'b0, 1'b1);
    end
    for (int k = 0; k < DP; k++) step(4'b0000, d, 4'b0001, 1'b1, 1'b1);

    // Stall with ports 0 and 3 loaded, then invalid grants.
    d = {32'h3333, 32'h0, 32'h0, 32'h1111};
    step(4'b1001, d, 4'b0000, 1'b0, 1'b1);
    step(4'b1001, d, 4'b0001, 1'b1, 1'b0);
    step(4'b0000, d, 4'b1000, 1'b1, 1'b0);
    step(4'b0000, d, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, d, 4'b0011, 1'b1, 1'b1);
    step(4'b0000, d, 4'b0000, 1'b0, 1'b1);
    async_reset_pulse();
    step(4'b0000, d, 4'b1000, 1'b1, 1'b1);
    async_reset_pulse();

    // Random traffic with a reset in the middle of the stream.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) async_reset_pulse();
      ordy = ($urandom_range(0, 3) != 0);
      iv   = NP'($urandom());
      for (int i = 0; i < NP; i++) d[i*DW +: DW] = $urandom();
      req = m_request(ordy);
      case ($urandom_range(0, 9))
        0:       gr = '0;
        1, 2:    gr = NP'($urandom());
        default: begin
          gr = '0;
          if (req != '0) begin
            int p;
            do p = $urandom_range(0, NP - 1); while (!req[p]);
            gr[p] = 1'b1;
          end
        end
      endcase
      ag = (|gr) ^ ($urandom_range(0, 19) == 0);
      step(iv, d, gr, ag, ordy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
